// File: rtl/basamak_tarayici_if.sv
// Handshake bundle for basamak_tarayici: start/operand/acknowledge in, busy/valid/result out.
interface basamak_tarayici_if #(
    parameter int NIBBLES = 4,
    parameter int POS_W   = 4
);
    logic                   baslat;
    logic [4*NIBBLES-1:0]   sayi;
    logic                   onay;
    logic                   mesgul;
    logic                   gecerli;
    logic [POS_W-1:0]       basamak;
    logic                   sifir;

    modport master (output baslat, sayi, onay, input mesgul, gecerli, basamak, sifir);
    modport slave  (input baslat, sayi, onay, output mesgul, gecerli, basamak, sifir);
endinterface

// File: rtl/basamak_tarayici.sv
// Sequential leading-one scanner, one nibble per clock from the MSB end.
// Optional feature macro: SCAN_EARLY_EXIT_EN (stop at the first nonzero nibble).
module basamak_tarayici #(
    parameter int NIBBLES = 4,
    parameter int POS_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    basamak_tarayici_if.slave   bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state;
    logic [W-1:0]     opnd;
    logic [KW-1:0]    k;
    logic             mesgul;
    logic             gecerli;
    logic [POS_W-1:0] basamak;
    logic             sifir;
    logic [3:0]       nib;
    logic [1:0]       p;
    logic [POS_W-1:0] pos;
`ifndef SCAN_EARLY_EXIT_EN
    logic             hit;
    logic [POS_W-1:0] hit_pos;
`endif

    function automatic logic [1:0] lead4(input logic [3:0] n);
        casez (n)
            4'b1???: lead4 = 2'd3;
            4'b01??: lead4 = 2'd2;
            4'b001?: lead4 = 2'd1;
            default: lead4 = 2'd0;
        endcase
    endfunction

    assign nib = opnd[4*k +: 4];
    assign p   = lead4(nib);
    assign pos = POS_W'({k, 2'b00}) + POS_W'(p);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            opnd    <= '0;
            k       <= '0;
            mesgul  <= 1'b0;
            gecerli <= 1'b0;
            basamak <= '0;
            sifir   <= 1'b0;
`ifndef SCAN_EARLY_EXIT_EN
            hit     <= 1'b0;
            hit_pos <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: if (bus.baslat) begin
                    opnd   <= bus.sayi;
                    k      <= KW'(NIBBLES - 1);
                    mesgul <= 1'b1;
                    state  <= SCAN;
`ifndef SCAN_EARLY_EXIT_EN
                    hit    <= 1'b0;
`endif
                end
                SCAN: begin
`ifdef SCAN_EARLY_EXIT_EN
                    if (nib != 4'd0) begin
                        basamak <= pos;
                        sifir   <= 1'b0;
                        gecerli <= 1'b1;
                        state   <= DONE;
                    end else if (k == '0) begin
                        basamak <= '0;
                        sifir   <= 1'b1;
                        gecerli <= 1'b1;
                        state   <= DONE;
                    end else begin
                        k <= k - KW'(1);
                    end
`else
                    // Full-length walk: remember the first hit, publish only at the last nibble
                    if (k == '0) begin
                        gecerli <= 1'b1;
                        state   <= DONE;
                        if (hit) begin
                            basamak <= hit_pos;
                            sifir   <= 1'b0;
                        end else if (nib != 4'd0) begin
                            basamak <= pos;
                            sifir   <= 1'b0;
                        end else begin
                            basamak <= '0;
                            sifir   <= 1'b1;
                        end
                    end else begin
                        k <= k - KW'(1);
                        if (!hit && nib != 4'd0) begin
                            hit     <= 1'b1;
                            hit_pos <= pos;
                        end
                    end
`endif
                end
                DONE: if (bus.onay) begin
                    gecerli <= 1'b0;
                    mesgul  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mesgul  = mesgul;
    assign bus.gecerli = gecerli;
    assign bus.basamak = basamak;
    assign bus.sifir   = sifir;
endmodule

// File: tb/tb_basamak_tarayici.sv
// Bench for basamak_tarayici: 16-bit and 12-bit instances driven in lockstep against a leading-one model.
module tb_basamak_tarayici;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    basamak_tarayici_if #(.NIBBLES(4), .POS_W(4)) b4();
    basamak_tarayici_if #(.NIBBLES(3), .POS_W(4)) b3();

    basamak_tarayici #(.NIBBLES(4), .POS_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    basamak_tarayici #(.NIBBLES(3), .POS_W(4)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

`ifdef SCAN_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] sayi;
        int          pos;
        int          zero;
        int          lat_e;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] v, input logic st, input logic ack);
        b4.sayi = v;        b3.sayi = v[11:0];
        b4.baslat = st;     b3.baslat = st;
        b4.onay = ack;      b3.onay = ack;
    endtask

    // Leading one by scanning bits from the top; latency from the nibble holding it.
    function automatic void ref_model(input logic [15:0] v, input int n,
                                      output int pos, output int zero, output int lat);
        pos = 0;
        zero = 1;
        for (int i = 4*n - 1; i >= 0; i--) begin
            if (v[i] && zero == 1) begin
                pos = i;
                zero = 0;
            end
        end
        lat = (EARLY && zero == 0) ? n - pos/4 : n;
    endfunction

    task automatic check_idle_zero(input string name);
        chk({name, " mesgul4"}, 32'(b4.mesgul), 0);
        chk({name, " gecerli4"}, 32'(b4.gecerli), 0);
        chk({name, " basamak4"}, 32'(b4.basamak), 0);
        chk({name, " sifir4"}, 32'(b4.sifir), 0);
        chk({name, " mesgul3"}, 32'(b3.mesgul), 0);
        chk({name, " basamak3"}, 32'(b3.basamak), 0);
    endtask

    task automatic wait_both(input string name, output int l4, output int l3);
        l4 = -1;
        l3 = -1;
        for (int c = 1; c <= 20 && (l4 < 0 || l3 < 0); c++) begin
            tick();
            if (l4 < 0 && b4.gecerli === 1'b1) l4 = c;
            if (l3 < 0 && b3.gecerli === 1'b1) l3 = c;
        end
        if (l4 < 0 || l3 < 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: l4=%0d l3=%0d", name, l4, l3);
        end
    endtask

    task automatic run_op(input string name, input logic [15:0] v,
                          input int e4pos, input int e4zero, input int e4lat);
        int e3pos, e3zero, e3lat, l4, l3;
        logic [3:0] held;
        ref_model(v, 3, e3pos, e3zero, e3lat);
        drive(v, 1'b1, 1'b0);
        tick();
        drive(~v, 1'b0, 1'b0);
        chk({name, " mesgul4 start"}, 32'(b4.mesgul), 1);
        chk({name, " mesgul3 start"}, 32'(b3.mesgul), 1);
        wait_both(name, l4, l3);
        chk({name, " lat4"}, 32'(l4), 32'(e4lat));
        chk({name, " lat3"}, 32'(l3), 32'(e3lat));
        chk({name, " basamak4"}, 32'(b4.basamak), 32'(e4pos));
        chk({name, " sifir4"}, 32'(b4.sifir), 32'(e4zero));
        chk({name, " basamak3"}, 32'(b3.basamak), 32'(e3pos));
        chk({name, " sifir3"}, 32'(b3.sifir), 32'(e3zero));
        held = b4.basamak;
        drive(~v, 1'b0, 1'b1);
        tick();
        drive(v, 1'b0, 1'b0);
        chk({name, " gecerli4 ack"}, 32'(b4.gecerli), 0);
        chk({name, " mesgul3 ack"}, 32'(b3.mesgul), 0);
        chk({name, " basamak4 kept"}, 32'(b4.basamak), 32'(held));
    endtask

    initial begin
        vec_t tab[7];
        int p, z, l, l4, l3;
        logic [15:0] v;

        tab[0] = '{16'h8000, 15, 0, 1};
        tab[1] = '{16'h0013,  4, 0, 3};
        tab[2] = '{16'h0001,  0, 0, 4};
        tab[3] = '{16'h0000,  0, 1, 4};
        tab[4] = '{16'h0F00, 11, 0, 2};
        tab[5] = '{16'h1234, 12, 0, 1};
        tab[6] = '{16'h00A0,  7, 0, 3};

        drive(16'h0, 1'b0, 1'b0);
        #12;
        check_idle_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_idle_zero("idle");

        foreach (tab[i])
            run_op($sformatf("vec%0d", i), tab[i].sayi, tab[i].pos, tab[i].zero,
                   EARLY ? tab[i].lat_e : 4);

        // Stall in DONE while pulsing start with a different operand
        drive(16'h0300, 1'b1, 1'b0);
        tick();
        drive(16'h0300, 1'b0, 1'b0);
        wait_both("hold", l4, l3);
        for (int c = 0; c < 5; c++) begin
            drive(16'h8000, 1'((c + 1) % 2), 1'b0);
            tick();
            chk("hold gecerli4", 32'(b4.gecerli), 1);
            chk("hold basamak4", 32'(b4.basamak), 9);
            chk("hold basamak3", 32'(b3.basamak), 9);
        end
        drive(16'h8000, 1'b0, 1'b1);
        tick();
        drive(16'h0, 1'b0, 1'b0);
        chk("hold ack mesgul4", 32'(b4.mesgul), 0);
        chk("hold ack gecerli3", 32'(b3.gecerli), 0);
        tick();
        chk("no restart mesgul4", 32'(b4.mesgul), 0);

        // Asynchronous reset in the middle of a scan
        drive(16'h0040, 1'b1, 1'b0);
        tick();
        drive(16'h0040, 1'b0, 1'b0);
        tick();
        chk("pre-reset mesgul4", 32'(b4.mesgul), 1);
        rst_n = 1'b0;
        #1;
        check_idle_zero("midscan reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after reset", 16'h0F00, 11, 0, EARLY ? 2 : 4);

        for (int i = 0; i < 1000; i++) begin
            v = 16'($urandom) >> $urandom_range(0, 16);
            ref_model(v, 4, p, z, l);
            run_op($sformatf("rnd %h", v), v, p, z, l);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
